// File: rtl/mem_align_unit_if.sv
// mem_align_unit_if: request, response and data-memory bundle for the
// alignment unit. slave is the unit's view; master is the pipeline/memory side.
interface mem_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int B = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [B-1:0]      mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_align_unit.sv
// mem_align_unit: sequential load/store alignment engine between the MEM stage
// and word-wide data memory. Drives byte-enabled word transactions and returns
// sign/zero-extended load data.
// Macro MEM_ALIGN_SPLIT_EN: when defined, word-crossing accesses are split into
// two beats; when undefined they are rejected with rsp_err and no memory traffic.
module mem_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             reset,
  mem_align_unit_if.slave bus
);
  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);
  // Wide enough to hold off+N without wrapping for every size.
  localparam int CW = OW + 2;
  localparam logic [CW-1:0] BC = CW'(B);

`ifdef MEM_ALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

  function automatic logic [3:0] size_bytes(input logic [2:0] s);
    case (s)
      3'b001, 3'b100: return 4'd1;
      3'b010, 3'b101: return 4'd2;
      3'b011, 3'b110: return 4'd4;
      3'b111:         return 4'd8;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic logic size_legal(input logic [2:0] s);
    return (s != 3'b000) && ((XLEN == 64) || (s < 3'b110));
  endfunction

  function automatic logic size_signed(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b011) || (s == 3'b111);
  endfunction

  state_t              state_q, state_d;
  logic                we_q;
  logic [2:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [B-1:0][7:0]   wdata_q, rd0_q;
  logic                in_err;
  logic [OW-1:0]       off_q;
  logic [CW-1:0]       off_w, n_q, end_q;
  logic [ADDR_W-1:0]   aligned;
  logic [B-1:0]        be0;
  logic [B-1:0][7:0]   rot, lo, hi, asm_b, ext_b;
  logic                sgn;

  assign off_q   = addr_q[OW-1:0];
  assign off_w   = CW'(off_q);
  assign n_q     = CW'(size_bytes(size_q));
  assign end_q   = off_w + n_q;
  assign aligned = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
  assign lo      = (state_q == WAIT0) ? bus.mem_rdata : rd0_q;

`ifdef MEM_ALIGN_SPLIT_EN
  logic [B-1:0][7:0] rd1_q;
  logic [B-1:0]      be1;
  logic              cross_q;
  assign cross_q = end_q > BC;
  assign hi      = (state_q == WAIT1) ? bus.mem_rdata : rd1_q;
  assign in_err  = !size_legal(bus.req_size);
`else
  logic [CW-1:0] in_end;
  // Nothing may reach memory for a crossing access, so reject it at accept.
  assign in_end = CW'(bus.req_addr[OW-1:0]) + CW'(size_bytes(bus.req_size));
  assign hi     = '0;
  assign in_err = !size_legal(bus.req_size) || (in_end > BC);
`endif

  // Per-lane byte enables: beat0 covers off..min(end,B)-1, beat1 0..end-B-1.
  for (genvar j = 0; j < B; j++) begin : g_lane
    assign be0[j] = (CW'(j) >= off_w) && (CW'(j) < end_q);
`ifdef MEM_ALIGN_SPLIT_EN
    assign be1[j] = (CW'(j) + BC) < end_q;
`endif
  end

  // Rotate store bytes into lanes; both beats share the rotation, be picks.
  always_comb begin
    rot = '0;
    for (int i = 0; i < B; i++) rot[off_q + OW'(i)] = wdata_q[i];
  end

  // Gather load bytes from one or two beats, then sign/zero extend.
  always_comb begin
    asm_b = '0;
    ext_b = '0;
    sgn   = 1'b0;
    for (int i = 0; i < B; i++) begin
      if ((off_w + CW'(i)) < BC) asm_b[i] = lo[off_q + OW'(i)];
      else                       asm_b[i] = hi[off_q + OW'(i)];
    end
    for (int i = 0; i < B; i++)
      if (CW'(i + 1) == n_q) sgn = asm_b[i][7] & size_signed(size_q);
    for (int i = 0; i < B; i++)
      ext_b[i] = (CW'(i) < n_q) ? asm_b[i] : {8{sgn}};
  end

  // Next-state and memory-side outputs; mem outputs derive only from latched
  // request state, so they hold steady while a request is stalled.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = in_err ? RESP : REQ0;
      end
      REQ0: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = aligned;
        bus.mem_be    = be0;
        bus.mem_wdata = rot;
        if (bus.mem_gnt) state_d = WAIT0;
      end
`ifdef MEM_ALIGN_SPLIT_EN
      WAIT0: if (bus.mem_rvalid) state_d = cross_q ? REQ1 : RESP;
      REQ1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = aligned + ADDR_W'(B);
        bus.mem_be    = be1;
        bus.mem_wdata = rot;
        if (bus.mem_gnt) state_d = WAIT1;
      end
      WAIT1: if (bus.mem_rvalid) state_d = RESP;
`else
      WAIT0: if (bus.mem_rvalid) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, beat capture and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      size_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd0_q         <= '0;
`ifdef MEM_ALIGN_SPLIT_EN
      rd1_q         <= '0;
`endif
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == WAIT0 && bus.mem_rvalid) rd0_q <= bus.mem_rdata;
`ifdef MEM_ALIGN_SPLIT_EN
      if (state_q == WAIT1 && bus.mem_rvalid) rd1_q <= bus.mem_rdata;
`endif
      bus.rsp_valid <= (state_d == RESP);
      bus.rsp_err   <= (state_q == IDLE) && (state_d == RESP);
      bus.rsp_rdata <= (state_d == RESP && state_q != IDLE && !we_q) ? ext_b : '0;
    end
  end
endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Load/store alignment engine between the MEM pipeline stage and data memory, generalising the combinational load extractor into a sequential, XLEN-parametrised unit. It takes one byte-addressed request at a time, drives byte-enable word-aligned memory transactions, and returns sign- or zero-extended load data. Accesses that cross a memory-word boundary are split into two beats.

## Interface
- XLEN, 32: data/word width, 32 or 64; B = XLEN/8 bytes per memory word
- ADDR_W, 32: byte-address width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  3  001 b, 010 h, 011 w, 100 bu, 101 hu, 110 wu, 111 d; 110/111 legal only when XLEN=64
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal size or unsplittable crossing access; valid with rsp_valid
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  write
- mem_addr  out  ADDR_W  word-aligned address, low log2(B) bits 0
- mem_be  out  B  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  read data or write ack; exactly one per granted request
- mem_rdata  in  XLEN  read data

## Operation
- N = bytes of req_size (1/2/4/8); off = req_addr mod B; cross = off+N > B.
- Request latched (we, size, addr, wdata) on req_valid && req_ready.
- FSM: IDLE -> REQ0 -> WAIT0 -> [REQ1 -> WAIT1] -> RESP -> IDLE.
  - IDLE: accept; illegal size -> RESP with err, no memory traffic.
  - REQ0: mem_req=1, addr = aligned(addr), be = bytes off..min(off+N,B)-1; hold until mem_gnt -> WAIT0.
  - WAIT0: on mem_rvalid capture lower bytes; -> REQ1 if cross, else RESP.
  - REQ1: mem_req=1, addr = aligned(addr)+B (wraps mod 2^ADDR_W), be = bytes 0..off+N-B-1; on gnt -> WAIT1.
  - WAIT1: on mem_rvalid capture upper bytes -> RESP.
  - RESP: rsp_valid=1 one cycle -> IDLE.
- Store data: byte i of req_wdata to lane (off+i) mod B; beat0 carries bytes 0..B-off-1, beat1 the rest.
- Load assembly: byte i from beat0 lane off+i (i < B-off), else beat1 lane i-(B-off). Sign extend from bit 8N-1 for b/h/w/d, zero extend for bu/hu/wu.
- Unaligned but non-crossing accesses complete in one beat, no error.
- mem_rvalid outside WAIT0/WAIT1 ignored.
- mem_req, mem_addr, mem_be, mem_we, mem_wdata stable while mem_req && !mem_gnt.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0.
- Single beat, gnt in first REQ0 cycle, rvalid next cycle: accept at cycle 0, mem_req cycle 1, rvalid cycle 2, rsp_valid cycle 3; new request accepted cycle 4.
- Split: +2 cycles minimum (rsp_valid cycle 5).
- Illegal size: rsp_valid with err at cycle 1.
- rsp_rdata/rsp_err registered, valid only while rsp_valid.
- Reset mid-operation: IDLE on next edge, mem_req low that edge, in-flight rvalid discarded, no response emitted.

## Configuration
- MEM_ALIGN_SPLIT_EN defined: crossing accesses split as above.
- Undefined: REQ1/WAIT1 absent; crossing access goes IDLE -> RESP with rsp_err=1, rsp_rdata 0, no mem_req.

## Test plan
- XLEN=32, lb @0x103, mem word 0x80FF_1234 -> one beat be=1000, rsp_rdata 0xFFFF_FF80, cycle 3.
- XLEN=32, lhu @0x102, word 0xBEEF_0000 -> be=1100, rsp_rdata 0x0000_BEEF, err 0.
- XLEN=32, lw @0x103, words 0xAA00_0000 @0x100 / 0x0033_2211 @0x104 -> two beats be 1000 then 0111, rsp_rdata 0x3322_11AA at cycle 5; without macro -> rsp_err=1 at cycle 1, no mem_req.
- XLEN=32, sw 0xDDCC_BBAA @0x102 -> beat0 addr 0x100 be=1100 wdata 0xBBAA_xxxx, beat1 0x104 be=0011 wdata 0xxxxx_DDCC.
- XLEN=32, size 111 -> rsp_err=1, rsp_rdata 0, no mem_req; XLEN=64 ld @0x8 -> be=0xFF, full 64-bit data.
- mem_gnt held low 4 cycles, then reset during WAIT0 -> mem outputs stable while stalled, IDLE next edge, late rvalid ignored, no rsp_valid.
